// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU: register file with a write-first
// writeback port, a busy scoreboard for RAW/WAW stalls, and one registered output slot.
module alu_issue_stage #(
   parameter int DSIZE = 16,
   parameter int NREG  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      instr,
   input  logic             wb_en,
   input  logic [3:0]       wb_addr,
   input  logic [DSIZE-1:0] wb_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DSIZE-1:0] A,
   output logic [DSIZE-1:0] B,
   output logic [2:0]       op,
   output logic [3:0]       imm,
   output logic [3:0]       rd_out,
   output logic             illegal
);

   logic [3:0] opc, rd, rs1, rs2;
   assign {opc, rd, rs1, rs2} = instr;

   logic [NREG-1:0][DSIZE-1:0] rf;
   logic [NREG-1:0]            busy, wb_clr, busy_eff, rd_set;
   logic                       is_alu, imm_form, hazard, slot_free;
   logic                       accept, accept_alu, accept_ill;
   logic [DSIZE-1:0]           opa, opb;

   assign is_alu   = ~opc[3];
   assign imm_form = opc[2];

   always_comb begin
      wb_clr = '0;
      if (wb_en && wb_addr != 4'd0) wb_clr[wb_addr] = 1'b1;
   end

   // Bits cleared by this cycle's writeback no longer block issue.
   assign busy_eff = busy & ~wb_clr;
   assign hazard   = is_alu && (busy_eff[rs1] || (!imm_form && busy_eff[rs2]) || busy_eff[rd]);

   assign slot_free  = !out_valid || out_ready;
   assign in_ready   = slot_free && !hazard;
   assign accept     = in_valid && in_ready;
   assign accept_alu = accept && is_alu;
   assign accept_ill = accept && !is_alu;

   always_comb begin
      rd_set = '0;
      if (accept_alu && rd != 4'd0) rd_set[rd] = 1'b1;
   end

   // Write-first operand read; R0 is hard-wired to zero.
   assign opa = (rs1 == 4'd0)             ? '0 :
                (wb_en && wb_addr == rs1) ? wb_data : rf[rs1];
   assign opb = (imm_form || rs2 == 4'd0) ? '0 :
                (wb_en && wb_addr == rs2) ? wb_data : rf[rs2];

   // Same-cycle clear and set on one register: the set is applied last and wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf   <= '0;
         busy <= '0;
      end else begin
         if (wb_en && wb_addr != 4'd0) rf[wb_addr] <= wb_data;
         busy <= (busy & ~wb_clr) | rd_set;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         A         <= '0;
         B         <= '0;
         op        <= '0;
         imm       <= '0;
         rd_out    <= '0;
         illegal   <= 1'b0;
      end else begin
         illegal <= accept_ill;
         if (accept_alu) begin
            out_valid <= 1'b1;
            A         <= opa;
            B         <= opb;
            op        <= opc[2:0];
            imm       <= imm_form ? rs2 : 4'd0;
            rd_out    <= rd;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the ALU.
- Accepts 16-bit instructions, decodes them, and reads a 16-entry register file.
- Drives the ALU operand bundle (A, B, op, imm) from a registered output slot with a valid/ready handshake.
- Holds a busy scoreboard so no operand is issued before its pending writeback lands; writeback enters through a dedicated write port.

Parameters:
- DSIZE, 16 (matches `DSIZE in define.v): register and operand data width.
- NREG, 16: number of registers; fixed by the 4-bit register fields, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instr is presented
- in_ready  out  1  stage accepts instr this cycle
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2/imm
- wb_en  in  1  writeback strobe
- wb_addr  in  4  writeback register
- wb_data  in  DSIZE  writeback value
- out_valid  out  1  ALU bundle valid
- out_ready  in  1  ALU side consumes bundle
- A  out  DSIZE  operand A
- B  out  DSIZE  operand B
- op  out  3  ALU op code
- imm  out  4  ALU immediate/shift amount
- rd_out  out  4  destination tag travelling with the bundle
- illegal  out  1  one-cycle pulse on dropped illegal instruction

Behaviour:
- Reset (async, rst=1):
  - all 16 registers = 0, busy mask = 0, out_valid = 0, illegal = 0.
  - A, B, op, imm, rd_out = 0.
  - A reset mid-handshake discards the held bundle.
- Decode:
  - opcode[3]=0 is an ALU instruction; op = opcode[2:0].
  - op 0-3 (register form): reads rs1 and rs2; A = R[rs1], B = R[rs2], imm = 0.
  - op 4-7 (immediate form): reads rs1 only; A = R[rs1], B = 0, imm = instr[3:0].
  - opcode[3]=1 is illegal.
- R0 always reads 0. Writes to R0 are ignored, and R0 is never marked busy.
- Operand read uses write-first bypass: if wb_en && wb_addr==rs && rs!=0, the operand takes wb_data in the same cycle.
- Hazard (ALU instructions only):
  - any register the instruction reads is busy and not being cleared by this cycle's wb, or
  - rd is busy and not being cleared (WAW).
  - Busy bits that wb clears in the same cycle do not count toward the hazard.
- Slot free: slot_free = !out_valid || out_ready.
- in_ready = slot_free && !(ALU instruction with hazard). Illegal instructions never hazard. in_ready is combinational from instr, busy, wb, and slot state.
- Accept = in_valid && in_ready. On accept of an ALU instruction, next cycle:
  - out_valid = 1, bundle registered (latency 1 cycle).
  - busy[rd] set if rd != 0.
- Accept of an illegal instruction: nothing issued, busy unchanged, illegal = 1 for exactly one cycle; out_valid drops if the old bundle was consumed.
- Output hold: while out_valid && !out_ready, A/B/op/imm/rd_out are held stable.
- Output drain: out_valid falls only when consumed with no new accept.
- Throughput: back-to-back issue at 1 instruction/cycle while out_ready=1 and no hazards.
- Writeback: on wb_en, R[wb_addr] = wb_data and busy[wb_addr] is cleared (both ignored for R0).
- Simultaneous set/clear on the same register: wb clears and issue sets busy[r] in the same cycle; set wins, final busy[r]=1. This is legal because WAW stalling is evaluated after the clear.
- wb_en to a non-busy register: permitted; write performed, busy stays 0.

Test Plan:
- Reset then R0/R1: after reset, issue ADD rd=1, rs1=0, rs2=0 (0x0100) with out_ready=1 -> out_valid next cycle, A=0, B=0, op=0, rd_out=1, busy[1]=1.
- Bypass: wb_en=1, wb_addr=2, wb_data=0x0033 in the same cycle as instr 0x1320 (SUB r3, r2, r0) -> A=0x0033, B=0, op=1; R2 reads 0x0033 afterwards.
- RAW stall: issue 0x0412, then 0x0541 (rs1=4 busy) -> in_ready=0 until wb_en, wb_addr=4; accepted in that wb cycle with A=wb_data.
- Immediate form: R5=0x000A, instr 0x4653 -> A=0x000A, B=0, op=4, imm=3, rd_out=6.
- Backpressure: out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0; out_ready=1 -> the next instruction is accepted the same cycle and appears one cycle later.
- Illegal and async reset: instr 0x8123 -> illegal pulses once, out_valid stays 0, busy unchanged. rst asserted mid-cycle while out_valid=1 -> out_valid=0 immediately, without waiting for clk.
